chan_readout_arbiter: RTL
=========================

// Module: chan_readout_arbiter
// PURPOSE
//  Packet-mode readout arbiter for the per-channel generate array (channels 0..N_CH-1;
//  channel SPECIAL_CH is the special module). Collects packets from each channel over
//  valid/ready, merges them onto one tagged output stream. Sits directly downstream of
//  the channel array, upstream of the serializer. Mid-packet stalls are bounded by a timeout abort.
// PARAMETERS
//  N_CH        9   number of channels (generate loop 0..8)
//  DATA_W      16  payload width
//  SPECIAL_CH  8   index of special channel
//  SPECIAL_PRI 1   1: special channel wins every arbitration point it requests; 0: plain round-robin
//  TIMEOUT     63  max idle cycles inside a packet before abort (>=1)
// PORTS
//  clk40      in   1               40 MHz clock
//  rstn       in   1               async active-low reset
//  in_valid   in   N_CH            per-channel word valid
//  in_data    in   N_CH*DATA_W     per-channel word, channel i at [i*DATA_W +: DATA_W]
//  in_last    in   N_CH            per-channel end-of-packet
//  in_ready   out  N_CH            per-channel accept
//  out_valid  out  1               output word valid
//  out_data   out  DATA_W          output word
//  out_ch     out  $clog2(N_CH)    source channel of word
//  out_last   out  1               end of packet
//  out_err    out  1               packet aborted by timeout (set on its last word)
//  out_ready  in   1               downstream accept
//  pkt_cnt    out  16              packets emitted (incl. aborted), wraps at 2^16
//  abort_cnt  out  8               timeout aborts, saturates at 255
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; state IDLE; RR pointer=0; FIFO empty.
//  - Output path: 2-entry FIFO {data,ch,last,err}. out_* driven from FIFO head; pop on out_valid&out_ready.
//    Simultaneous push+pop keeps count. Never push when count==2.
//  - in_ready[i] = (state==STREAM) & (grant==i) & (count<2); count is registered, so no out_ready->in_ready comb path.
//    Accepted word (in_valid&in_ready) written into FIFO same edge; visible on out_* next cycle -> latency 1.
//  - FSM:
//    IDLE: any in_valid set -> pick winner: if SPECIAL_PRI and in_valid[SPECIAL_CH] -> SPECIAL_CH,
//          else first requester at or after RR pointer (mod N_CH). Register grant, -> STREAM. 1 cycle arbitration bubble.
//    STREAM: on accepted word with in_last=1 -> RR pointer=(grant+1) mod N_CH, -> IDLE.
//            Idle counter: reset to 0 on every accept; increments each cycle in_valid[grant]=0.
//            FIFO-full stalls (count==2) do NOT increment it. Counter reaching TIMEOUT -> ABORT.
//    ABORT: when count<2 push {data=0, ch=grant, last=1, err=1}; RR pointer advances as for last; -> IDLE.
//            in_ready all 0 here; remaining words of aborted packet arrive later as a new packet.
//  - Words from a non-granted channel are never accepted (in_ready=0); channels hold data.
//  - Special channel with SPECIAL_PRI=1 does not pre-empt a packet in progress; it wins only in IDLE.
//    RR pointer unaffected by special wins.
//  - pkt_cnt +1 per FIFO push with last=1; abort_cnt +1 per ABORT push, saturating.
//  - Reset mid-packet: packet discarded, FIFO cleared, no error word emitted.
// STRUCTURE
//  - Package chan_readout_pkg: localparam CH_W=$clog2(N_CH); typedef enum {IDLE,STREAM,ABORT} state_t;
//    typedef struct {data, ch, last, err} rd_word_t.
//  - One sub-module: rd_fifo2 (2-entry sync FIFO, push/pop/count, async active-low reset).
//  - Arbiter: combinational rotate-and-priority-encode in top.
// TESTING
//  1. Reset: drive inputs active during rstn=0 -> all outputs 0, in_ready=0; first grant after release goes to lowest requester.
//  2. RR: ch0,3,5 each send 2-word packet simultaneously, SPECIAL_PRI=0 -> out_ch order 0,0,3,3,5,5; last on 2nd of each; pkt_cnt=3.
//  3. Priority: ch2 mid-packet, ch8 and ch4 request -> ch2 completes, then ch8, then ch4.
//  4. Backpressure: out_ready=0 for 10 cycles during 5-word packet -> 2 words buffered, in_ready low, no idle count, no loss or reorder.
//  5. Timeout: TIMEOUT=4, ch1 sends 1 word then drops valid -> after 4 idle cycles word {0,ch1,last=1,err=1}; abort_cnt=1.
//  6. Reset mid-packet at word 3 of 6 -> FIFO empty, no err word; next packet starts clean.

Source files
------------

// File: rtl/chan_readout_arbiter_pkg.sv
// Shared types for the channel readout arbiter: FSM states and the
// tagged output word carried through the output FIFO.
package chan_readout_pkg;

  localparam int N_CH_DEF   = 9;
  localparam int DATA_W_DEF = 16;
  localparam int CH_W       = $clog2(N_CH_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    ABORT  = 2'd2
  } state_t;

  // Field order matches the packed vector the top pushes into the FIFO:
  // {data, ch, last, err}.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [CH_W-1:0]       ch;
    logic                  last;
    logic                  err;
  } rd_word_t;

endpackage

// File: rtl/chan_readout_arbiter_rd_fifo2.sv
// Two-entry synchronous FIFO holding tagged readout words. Storage is not
// reset; only pointers and occupancy are, so an empty FIFO is the clean state.
module rd_fifo2
  import chan_readout_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/chan_readout_arbiter.sv
// Packet-mode readout arbiter: grants one channel at a time, forwards its
// packet into a 2-entry output FIFO tagged with the channel index, and aborts
// packets that stall mid-stream for TIMEOUT cycles with an error terminator.
module chan_readout_arbiter
  import chan_readout_pkg::*;
#(
  parameter int N_CH        = 9,
  parameter int DATA_W      = 16,
  parameter int SPECIAL_CH  = 8,
  parameter int SPECIAL_PRI = 1,
  parameter int TIMEOUT     = 63
) (
  input  logic                     clk40,
  input  logic                     rstn,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(N_CH)-1:0]  out_ch,
  output logic                     out_last,
  output logic                     out_err,
  input  logic                     out_ready,
  output logic [15:0]              pkt_cnt,
  output logic [7:0]               abort_cnt
);

  localparam int CW = $clog2(N_CH);
  localparam int FW = DATA_W + CW + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state_q;
  logic [CW-1:0]   grant_q;
  logic [CW-1:0]   rr_ptr_q;
  logic            special_q;
  logic [TW-1:0]   idle_q;
  logic [15:0]     pkt_cnt_q;
  logic [7:0]      abort_cnt_q;

  logic [CW:0]     scan_idx;
  logic            rr_found;
  logic [CW-1:0]   rr_win;
  logic            req_any;
  logic [CW-1:0]   win_ch;
  logic            win_special;

  logic            g_valid;
  logic            g_last;
  logic [DATA_W-1:0] g_data;

  logic [1:0]      fifo_cnt;
  logic            fifo_room;
  logic            accept;
  logic            abort_push;
  logic            push;
  logic            pop;
  logic [FW-1:0]   push_word;
  logic [FW-1:0]   head_word;
  logic [CW-1:0]   rr_ptr_d;

  logic [DATA_W-1:0] head_data;
  logic [CW-1:0]     head_ch;
  logic              head_last;
  logic              head_err;

  // Rotate requests to start at the RR pointer and take the first one; the
  // special channel overrides the rotation when priority mode is enabled.
  always_comb begin
    rr_found    = 1'b0;
    rr_win      = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (scan_idx >= (CW+1)'(N_CH)) scan_idx = scan_idx - (CW+1)'(N_CH);
      if (!rr_found && in_valid[scan_idx[CW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = scan_idx[CW-1:0];
      end
    end
    win_ch      = rr_win;
    win_special = 1'b0;
    if ((SPECIAL_PRI != 0) && in_valid[SPECIAL_CH]) begin
      win_ch      = CW'(SPECIAL_CH);
      win_special = 1'b1;
    end
  end

  assign req_any = |in_valid;

  // Select the granted channel's handshake and payload.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q == CW'(i)) begin
        g_valid = in_valid[i];
        g_last  = in_last[i];
        g_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready depends only on registered state and FIFO occupancy, never on out_ready.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = (state_q == STREAM) && (grant_q == CW'(i)) && fifo_room;
    end
  end

  assign fifo_room  = (fifo_cnt != 2'd2);
  assign accept     = (state_q == STREAM) && g_valid && fifo_room;
  assign abort_push = (state_q == ABORT) && fifo_room;
  assign push       = accept || abort_push;
  assign push_word  = accept ? {g_data, grant_q, g_last, 1'b0}
                             : {{DATA_W{1'b0}}, grant_q, 1'b1, 1'b1};

  // Packets won through special priority leave the rotation where it was.
  assign rr_ptr_d = special_q ? rr_ptr_q
                  : ((grant_q == CW'(N_CH-1)) ? '0 : grant_q + 1'b1);

  // Arbitration FSM: pick a winner in IDLE, forward its packet in STREAM,
  // emit the error terminator in ABORT.
  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      special_q <= 1'b0;
      idle_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            grant_q   <= win_ch;
            special_q <= win_special;
            idle_q    <= '0;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            idle_q <= '0;
            if (g_last) begin
              rr_ptr_q <= rr_ptr_d;
              state_q  <= IDLE;
            end
          end else if (!g_valid) begin
            if (idle_q == TW'(TIMEOUT - 1)) state_q <= ABORT;
            idle_q <= idle_q + 1'b1;
          end
        end
        ABORT: begin
          if (fifo_room) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Packet counter wraps; abort counter saturates.
  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (push && push_word[1]) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (abort_push && (abort_cnt_q != 8'hFF)) abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  rd_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk_i   (clk40),
    .rst_ni  (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_word),
    .rdata_o (head_word),
    .count_o (fifo_cnt)
  );

  assign {head_data, head_ch, head_last, head_err} = head_word;

  // Fields are forced to zero while empty so unwritten storage never leaks out.
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = out_valid ? head_data : '0;
  assign out_ch    = out_valid ? head_ch   : '0;
  assign out_last  = out_valid && head_last;
  assign out_err   = out_valid && head_err;
  assign pop       = out_valid && out_ready;
  assign pkt_cnt   = pkt_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule
